// File: rtl/uart_pkg.sv
// Shared constants and state encodings for the 8N1 UART transceiver.
// Imported by the bit timer and the transceiver top level.
package uart_pkg;

    localparam int DATA_WIDTH    = 8;
    localparam int CLK_FREQ      = 50_000_000;
    localparam int BAUD_RATE     = 115200;
    localparam int CLKS_PER_BIT  = CLK_FREQ / BAUD_RATE;
    localparam int COUNT_REG_LEN = $clog2(CLKS_PER_BIT);
    localparam int BIT_IDX_LEN   = $clog2(DATA_WIDTH);

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

    typedef enum logic [3:0] {
        RX_IDLE    = 4'd0,
        RX_START   = 4'd1,
        RX_DATA    = 4'd2,
        RX_STOP    = 4'd3,
        RX_CLEANUP = 4'd4
    } rx_state_e;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_bit_timer.sv
// Free-running bit-period tick counter with synchronous clear.
// Ports: clk, rst_n (async low), clr_i; tc_o = last tick of a bit, half_o = mid-bit.
module uart_bit_timer
    import uart_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    output logic tc_o,
    output logic half_o
);

    localparam logic [COUNT_REG_LEN-1:0] TC_VAL   = COUNT_REG_LEN'(CLKS_PER_BIT - 1);
    localparam logic [COUNT_REG_LEN-1:0] HALF_VAL = COUNT_REG_LEN'(CLKS_PER_BIT / 2 - 1);

    logic [COUNT_REG_LEN-1:0] cnt_q;
    logic [COUNT_REG_LEN-1:0] cnt_d;

    assign tc_o   = (cnt_q == TC_VAL);
    assign half_o = (cnt_q == HALF_VAL);

    always_comb begin
        cnt_d = cnt_q + COUNT_REG_LEN'(1);
        if (clr_i || tc_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_transceiver.sv
// Full-duplex 8N1 UART: TX serialiser and RX deserialiser on one clock.
// Ports: clk, areset (async low); tx_data_valid/tx_byte in, tx_busy/tx_serial/tx_done out;
// rx_data in, rx_byte/rx_valid/rx_busy out.
module uart_transceiver
    import uart_pkg::*;
(
    input  logic                  clk,
    input  logic                  areset,
    input  logic                  tx_data_valid,
    input  logic [DATA_WIDTH-1:0] tx_byte,
    output logic                  tx_busy,
    output logic                  tx_serial,
    output logic                  tx_done,
    input  logic                  rx_data,
    output logic [DATA_WIDTH-1:0] rx_byte,
    output logic                  rx_valid,
    output logic                  rx_busy
);

    // ---------------- TX path ----------------
    tx_state_e              tx_state_q, tx_state_d;
    logic [DATA_WIDTH-1:0]  tx_shift_q, tx_shift_d;
    logic [BIT_IDX_LEN-1:0] tx_bit_q, tx_bit_d;
    logic                   tx_serial_q, tx_serial_d;
    logic                   tx_busy_q, tx_busy_d;
    logic                   tx_done_q, tx_done_d;
    logic                   tx_clr, tx_tick, tx_half_unused;
    logic                   data_bits_done;

    uart_bit_timer u_tx_timer (
        .clk    (clk),
        .rst_n  (areset),
        .clr_i  (tx_clr),
        .tc_o   (tx_tick),
        .half_o (tx_half_unused)
    );

    assign data_bits_done = (tx_bit_q == BIT_IDX_LEN'(DATA_WIDTH - 1));

    always_comb begin
        tx_state_d  = tx_state_q;
        tx_shift_d  = tx_shift_q;
        tx_bit_d    = tx_bit_q;
        tx_serial_d = tx_serial_q;
        tx_busy_d   = tx_busy_q;
        tx_done_d   = 1'b0;
        tx_clr      = 1'b0;
        unique case (tx_state_q)
            TX_IDLE: begin
                tx_clr = 1'b1;
                // A request coinciding with the tx_done pulse is dropped.
                if (tx_data_valid && !tx_done_q) begin
                    tx_shift_d  = tx_byte;
                    tx_bit_d    = '0;
                    tx_serial_d = START_LEVEL;
                    tx_busy_d   = 1'b1;
                    tx_state_d  = TX_START;
                end
            end
            TX_START: begin
                if (tx_tick) begin
                    tx_serial_d = tx_shift_q[0];
                    tx_state_d  = TX_DATA;
                end
            end
            TX_DATA: begin
                if (tx_tick) begin
                    if (data_bits_done) begin
                        tx_serial_d = IDLE_LEVEL;
                        tx_state_d  = TX_STOP;
                    end else begin
                        tx_shift_d  = tx_shift_q >> 1;
                        tx_bit_d    = tx_bit_q + BIT_IDX_LEN'(1);
                        tx_serial_d = tx_shift_q[1];
                    end
                end
            end
            TX_STOP: begin
                if (tx_tick) begin
                    tx_busy_d  = 1'b0;
                    tx_done_d  = 1'b1;
                    tx_state_d = TX_IDLE;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            tx_state_q  <= TX_IDLE;
            tx_shift_q  <= '0;
            tx_bit_q    <= '0;
            tx_serial_q <= IDLE_LEVEL;
            tx_busy_q   <= 1'b0;
            tx_done_q   <= 1'b0;
        end else begin
            tx_state_q  <= tx_state_d;
            tx_shift_q  <= tx_shift_d;
            tx_bit_q    <= tx_bit_d;
            tx_serial_q <= tx_serial_d;
            tx_busy_q   <= tx_busy_d;
            tx_done_q   <= tx_done_d;
        end
    end

    assign tx_serial = tx_serial_q;
    assign tx_busy   = tx_busy_q;
    assign tx_done   = tx_done_q;

    // ---------------- RX path ----------------
    logic [1:0]             rx_data_ff;
    logic                   rx_s;
    rx_state_e              rx_state_q, rx_state_d;
    logic [DATA_WIDTH-1:0]  rx_shift_q, rx_shift_d;
    logic [BIT_IDX_LEN-1:0] rx_bit_q, rx_bit_d;
    logic [DATA_WIDTH-1:0]  rx_byte_q, rx_byte_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   rx_clr, rx_tick, rx_half;

    uart_bit_timer u_rx_timer (
        .clk    (clk),
        .rst_n  (areset),
        .clr_i  (rx_clr),
        .tc_o   (rx_tick),
        .half_o (rx_half)
    );

    assign rx_s = rx_data_ff[1];

    always_comb begin
        rx_state_d = rx_state_q;
        rx_shift_d = rx_shift_q;
        rx_bit_d   = rx_bit_q;
        rx_byte_d  = rx_byte_q;
        rx_valid_d = 1'b0;
        rx_clr     = 1'b0;
        unique case (rx_state_q)
            RX_IDLE: begin
                rx_clr = 1'b1;
                if (rx_s == START_LEVEL) begin
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                // Restart the timer at mid-start so later ticks land mid-bit.
                if (rx_half) begin
                    rx_clr = 1'b1;
                    if (rx_s == START_LEVEL) begin
                        rx_bit_d   = '0;
                        rx_state_d = RX_DATA;
                    end else begin
                        rx_state_d = RX_IDLE;
                    end
                end
            end
            RX_DATA: begin
                if (rx_tick) begin
                    rx_shift_d[rx_bit_q] = rx_s;
                    if (rx_bit_q == BIT_IDX_LEN'(DATA_WIDTH - 1)) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + BIT_IDX_LEN'(1);
                    end
                end
            end
            RX_STOP: begin
                if (rx_tick) begin
                    if (rx_s == IDLE_LEVEL) begin
                        rx_byte_d  = rx_shift_q;
                        rx_valid_d = 1'b1;
                    end
                    rx_state_d = RX_CLEANUP;
                end
            end
            RX_CLEANUP: begin
                if (rx_s == IDLE_LEVEL) begin
                    rx_state_d = RX_IDLE;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            rx_data_ff <= 2'b11;
            rx_state_q <= RX_IDLE;
            rx_shift_q <= '0;
            rx_bit_q   <= '0;
            rx_byte_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            rx_data_ff <= {rx_data_ff[0], rx_data};
            rx_state_q <= rx_state_d;
            rx_shift_q <= rx_shift_d;
            rx_bit_q   <= rx_bit_d;
            rx_byte_q  <= rx_byte_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    assign rx_byte  = rx_byte_q;
    assign rx_valid = rx_valid_q;
    assign rx_busy  = (rx_state_q != RX_IDLE);

endmodule

// File: tb/tb_uart_transceiver.sv
// Loopback bench for uart_transceiver: scoreboard of sent bytes,
// monitor compares every rx_valid and tx_done against it.
module tb_uart_transceiver;

    localparam int CPB   = 50_000_000 / 115200;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       areset;
    logic       tx_data_valid;
    logic [7:0] tx_byte;
    logic       tx_busy, tx_serial, tx_done;
    logic       rx_data;
    logic [7:0] rx_byte;
    logic       rx_valid, rx_busy;

    logic lb  = 1'b1;
    logic drv = 1'b1;

    assign rx_data = lb ? tx_serial : drv;

    always #10 clk = ~clk;

    uart_transceiver dut (
        .clk           (clk),
        .areset        (areset),
        .tx_data_valid (tx_data_valid),
        .tx_byte       (tx_byte),
        .tx_busy       (tx_busy),
        .tx_serial     (tx_serial),
        .tx_done       (tx_done),
        .rx_data       (rx_data),
        .rx_byte       (rx_byte),
        .rx_valid      (rx_valid),
        .rx_busy       (rx_busy)
    );

    int checks = 0;
    int errors = 0;
    int rxv_count = 0;
    logic [7:0] rx_q[$];
    logic [7:0] done_q[$];
    logic [7:0] last_good = 8'h00;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a result.
    initial begin : monitor
        int busy_cnt;
        busy_cnt = 0;
        forever begin
            @(negedge clk);
            if (!areset) begin
                busy_cnt = 0;
            end else begin
                if (tx_busy) busy_cnt++;
                if (rx_valid) begin
                    rxv_count++;
                    if (rx_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rx_unexpected actual=%0h required=none", rx_byte);
                    end else begin
                        chk("rx_byte", {24'h0, rx_byte}, {24'h0, rx_q.pop_front()});
                    end
                end
                if (tx_done) begin
                    if (done_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL tx_done_unexpected actual=1 required=0");
                    end else begin
                        chk("done_rx_byte", {24'h0, rx_byte}, {24'h0, done_q.pop_front()});
                        chk("frame_len", busy_cnt, FRAME);
                        chk("busy_at_done", {31'h0, tx_busy}, 32'h0);
                    end
                    busy_cnt = 0;
                end
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while ((tx_busy || tx_done) && n < 2 * FRAME) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", {31'h0, (tx_busy || tx_done)}, 32'h0);
    endtask

    task automatic send(input logic [7:0] b);
        wait_idle();
        tx_byte       = b;
        tx_data_valid = 1'b1;
        @(negedge clk);
        tx_data_valid = 1'b0;
        rx_q.push_back(b);
        done_q.push_back(b);
        last_good = b;
    endtask

    task automatic drive_frame(input logic [7:0] b, input logic stop);
        drv = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            drv = b[i];
            repeat (CPB) @(negedge clk);
        end
        drv = stop;
        repeat (CPB) @(negedge clk);
        drv = 1'b1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_tx_serial"}, {31'h0, tx_serial}, 32'h1);
        chk({tag, "_tx_busy"},   {31'h0, tx_busy},   32'h0);
        chk({tag, "_tx_done"},   {31'h0, tx_done},   32'h0);
        chk({tag, "_rx_byte"},   {24'h0, rx_byte},   32'h0);
        chk({tag, "_rx_valid"},  {31'h0, rx_valid},  32'h0);
        chk({tag, "_rx_busy"},   {31'h0, rx_busy},   32'h0);
    endtask

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int c0;
        int len;
        logic [7:0] rb;

        areset        = 1'b0;
        tx_data_valid = 1'b0;
        tx_byte       = 8'h00;
        #100;
        areset = 1'b1;
        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");

        // Single frame, start bit must appear right after acceptance.
        send(8'hAA);
        chk("start_bit", {31'h0, tx_serial}, 32'h0);
        chk("busy_on_accept", {31'h0, tx_busy}, 32'h1);
        repeat (200) @(negedge clk);
        chk("rx_busy_mid", {31'h0, rx_busy}, 32'h1);
        wait_idle();

        // Back-to-back sequence 0xAA..0xB2.
        c0 = rxv_count;
        for (int i = 0; i < 9; i++) begin
            send(8'hAA + 8'(i));
        end
        wait_idle();
        chk("rxv_count9", rxv_count - c0, 9);

        // Request mid-frame must be ignored.
        send(8'h3C);
        repeat ($urandom_range(5, FRAME - 50)) @(negedge clk);
        tx_byte       = 8'h55;
        tx_data_valid = 1'b1;
        @(negedge clk);
        tx_data_valid = 1'b0;
        wait_idle();
        repeat (4) @(negedge clk);

        // Short glitch on the line.
        c0  = rxv_count;
        lb  = 1'b0;
        len = $urandom_range(20, 200);
        drv = 1'b0;
        repeat (len) @(negedge clk);
        chk("glitch_busy", {31'h0, rx_busy}, 32'h1);
        drv = 1'b1;
        repeat (400) @(negedge clk);
        chk("glitch_idle", {31'h0, rx_busy}, 32'h0);
        chk("glitch_byte", {24'h0, rx_byte}, {24'h0, last_good});
        chk("glitch_novalid", rxv_count - c0, 0);

        // Framing error, then a good frame.
        drive_frame(8'hFF, 1'b0);
        repeat (2 * CPB) @(negedge clk);
        chk("ferr_byte", {24'h0, rx_byte}, {24'h0, last_good});
        chk("ferr_novalid", rxv_count - c0, 0);
        chk("ferr_idle", {31'h0, rx_busy}, 32'h0);
        lb = 1'b1;
        send(8'h12);
        wait_idle();
        chk("after_ferr", {24'h0, rx_byte}, 32'h12);

        // Random payloads.
        for (int i = 0; i < 2; i++) begin
            rb = 8'($urandom_range(0, 255));
            send(rb);
        end
        wait_idle();

        // Reset in the middle of a frame.
        c0 = rxv_count;
        send(8'($urandom_range(0, 255)));
        repeat ($urandom_range(100, 4000)) @(negedge clk);
        #3;
        areset = 1'b0;
        rx_q.delete();
        done_q.delete();
        #1;
        chk_reset_outputs("midreset");
        @(negedge clk);
        repeat (3) @(negedge clk);
        areset = 1'b1;
        repeat (FRAME + 100) @(negedge clk);
        chk("abort_novalid", rxv_count - c0, 0);
        chk("abort_idle", {31'h0, tx_busy}, 32'h0);

        chk("sb_empty", rx_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_transceiver.md
Name: uart_transceiver

Overview:
- Full-duplex 8N1 UART: transmit path serialises a parallel byte onto tx_serial; receive path deserialises rx_data into rx_byte.
- Both paths share one system clock and reset, and run on a fixed clock-to-baud divisor.
- Sits between the host-side byte interface and the off-chip serial pins.
- Verification connects tx_serial to rx_data (loopback).

Parameters:
- DATA_WIDTH, 8, data bits per frame.
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- BAUD_RATE, 115200, serial bit rate.
- CLKS_PER_BIT, CLK_FREQ/BAUD_RATE (434), clock cycles per serial bit.
- COUNT_REG_LEN, $clog2(CLKS_PER_BIT), width of the tick counters (derived, not overridden).

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- areset  in  1  asynchronous, active-low reset.
- tx_data_valid  in  1  one-cycle request to send tx_byte.
- tx_byte  in  DATA_WIDTH  byte to transmit, sampled when the request is accepted.
- tx_busy  out  1  high while a frame is in flight.
- tx_serial  out  1  serial output; idles high.
- tx_done  out  1  one-cycle pulse at the end of the stop bit.
- rx_data  in  1  asynchronous serial input.
- rx_byte  out  DATA_WIDTH  last correctly received byte; held until the next good frame.
- rx_valid  out  1  one-cycle pulse when rx_byte updates.
- rx_busy  out  1  high from start-bit detection until return to IDLE.

Behaviour:
- Reset values (areset low):
  - tx_serial=1; tx_busy=0; tx_done=0.
  - rx_byte=0; rx_valid=0; rx_busy=0.
  - Both FSMs return to IDLE; all counters are zero; both synchroniser flops are set to 1.
- Reset mid-frame aborts immediately. No tx_done or rx_valid is produced for the aborted frame.
- Frame format: 1 start bit (0), DATA_WIDTH data bits LSB first, 1 stop bit (1). No parity.
- TX accept:
  - In IDLE with tx_data_valid=1: latch tx_byte, set tx_busy=1, and drive tx_serial=0 from the next cycle.
  - tx_data_valid while busy is ignored, including in the cycle tx_done is high.
- TX bit timing:
  - ticks_counter counts 0..CLKS_PER_BIT-1; the next_bit strobe fires at terminal count.
  - bit_counter counts data bits; data_bits_done flags the last data bit.
  - Each bit lasts exactly CLKS_PER_BIT cycles; the frame lasts 10*CLKS_PER_BIT cycles.
- TX end of frame: at the last tick of the stop bit, tx_done pulses high for 1 cycle, tx_busy falls in that same cycle, and tx_serial stays 1.
- RX synchroniser: rx_data passes through 2 flops (rx_data_ff[0], rx_data_ff[1]). All RX decisions use rx_data_ff[1].
- RX FSM (4-bit state register: IDLE, START, DATA, STOP, CLEANUP):
  - IDLE: on rx_data_ff[1]==0, go to START with rx_busy=1 and the tick counter cleared.
  - START: at CLKS_PER_BIT/2 ticks, resample. If 0, go to DATA. If 1 (glitch), go to IDLE with rx_busy=0.
  - DATA: every CLKS_PER_BIT ticks (mid-bit), shift the sample into bit position bit_index, LSB first. After DATA_WIDTH bits, go to STOP.
  - STOP: after CLKS_PER_BIT ticks (mid-stop), check the sample.
    - If 1: load rx_byte from the shift register, pulse rx_valid for 1 cycle, go to CLEANUP.
    - If 0 (framing error): rx_byte and rx_valid are not touched; go to CLEANUP.
  - CLEANUP: wait until rx_data_ff[1]==1, then go to IDLE and drop rx_busy.
- Loopback ordering: rx_valid (mid-stop plus 2-cycle sync delay) precedes tx_done (end of stop bit) by about CLKS_PER_BIT/2 cycles. Therefore rx_byte equals the transmitted byte whenever tx_done is high.
- Back-to-back frames: a new TX request accepted in the cycle after tx_done produces a valid frame. RX must resynchronise on it, because its CLEANUP exits before the next start bit.

Decomposition:
- Package uart_pkg:
  - DATA_WIDTH, CLKS_PER_BIT, COUNT_REG_LEN constants.
  - RX state enum (4-bit encoding).
  - Line-level constants IDLE_LEVEL=1, START_LEVEL=0.
- One sub-module: uart_bit_timer, a tick counter with terminal-count and half-count strobes and a synchronous clear. It is instantiated once in the TX path and once in the RX path.
- The TX and RX FSMs stay in the top level.

Test Plan:
- Reset pulse (areset low for 100 ns), line idle -> tx_serial=1, tx_busy=0, rx_byte=0x00, rx_valid=0, rx_busy=0.
- Loopback, send 0xAA -> tx_busy high for 10*434 cycles; rx_valid pulse with rx_byte=0xAA; then tx_done pulse with rx_byte still 0xAA.
- Loopback sequence 0xAA..0xB2 (9 bytes), each issued once tx_busy falls -> each tx_done shows rx_byte equal to the byte sent, and there are exactly 9 rx_valid pulses.
- tx_data_valid pulsed mid-frame with 0x55 during a 0x3C transfer -> 0x55 ignored; only 0x3C received; frame length unchanged.
- Drive rx_data low for 100 cycles (less than 217) then high -> RX returns to IDLE, no rx_valid, rx_byte unchanged.
- Frame 0xFF with stop bit forced 0, then a normal 0x12 -> no rx_valid for the first frame; rx_byte=0x12 after the second. areset asserted mid-frame -> all outputs return to reset values immediately.
